// File: rtl/painterengine_gpu_dma_pkg.sv
// Shared definitions for the GPU DMA reader/writer: state and error encodings, AXI constants.
package painterengine_gpu_dma_pkg;

    // Bit 4 of the state marks the terminal error states.
    typedef enum logic [4:0] {
        ST_ROUTING     = 5'h00,
        ST_CHECK       = 5'h01,
        ST_CALC        = 5'h02,
        ST_ADDR        = 5'h03,
        ST_DATA        = 5'h04,
        ST_DONE        = 5'h05,
        ST_ERR_ROUTING = 5'h11,
        ST_ERR_ALIGN   = 5'h12,
        ST_ERR_LENGTH  = 5'h13,
        ST_ERR_TIMEOUT = 5'h14,
        ST_ERR_RRESP   = 5'h15,
        ST_ERR_RLAST   = 5'h16
    } state_e;

    typedef enum logic [2:0] {
        ET_NONE    = 3'd0,
        ET_ROUTING = 3'd1,
        ET_ALIGN   = 3'd2,
        ET_LENGTH  = 3'd3,
        ET_TIMEOUT = 3'd4,
        ET_RRESP   = 3'd5,
        ET_RLAST   = 3'd6
    } err_type_e;

    localparam logic [2:0] AXI_ARSIZE_4B   = 3'b010;
    localparam logic [1:0] AXI_ARBURST_INC = 2'b01;
    localparam logic [3:0] AXI_ARCACHE     = 4'b0010;
    localparam logic [8:0] BURST_BOUNDARY  = 9'd256;

    function automatic err_type_e err_code(input state_e s);
        case (s)
            ST_ERR_ROUTING: return ET_ROUTING;
            ST_ERR_ALIGN:   return ET_ALIGN;
            ST_ERR_LENGTH:  return ET_LENGTH;
            ST_ERR_TIMEOUT: return ET_TIMEOUT;
            ST_ERR_RRESP:   return ET_RRESP;
            ST_ERR_RLAST:   return ET_RLAST;
            default:        return ET_NONE;
        endcase
    endfunction

endpackage

// File: rtl/painterengine_gpu_dma_burst_calc.sv
// Next burst address and length; a burst never crosses a 1 KB (256-word) boundary.
module painterengine_gpu_dma_burst_calc
    import painterengine_gpu_dma_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [31:0] offset_i,
    input  logic [31:0] len_i,
    output logic [31:0] raddr_o,
    output logic [8:0]  burst_o
);
    logic [7:0]  word_in_kb;
    logic [8:0]  room;
    logic [31:0] remain;

    always_comb begin
        word_in_kb = addr_i[9:2] + offset_i[7:0];
        room       = BURST_BOUNDARY - {1'b0, word_in_kb};
        remain     = len_i - offset_i;
        raddr_o    = addr_i + {offset_i[29:0], 2'b00};
        if (remain < {23'd0, room}) begin
            burst_o = remain[8:0];
        end else begin
            burst_o = room;
        end
    end
endmodule

// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read master feeding one of four one-hot routed channels as a valid/next stream.
// Optional watchdog: define PAINTERENGINE_GPU_READER_TIMEOUT_EN.
module painterengine_gpu_dma_reader
    import painterengine_gpu_dma_pkg::*;
#(
    parameter int PARAM_DATA_ALIGN = 32,
    parameter int PARAM_TIMEOUT    = 256
) (
    input  logic         i_wire_clock,
    input  logic         i_wire_resetn,
    input  logic [3:0]   i_wire_router,
    input  logic [127:0] i_wire_address,
    input  logic [127:0] i_wire_length,
    output logic [127:0] o_wire_data,
    output logic [3:0]   o_wire_data_valid,
    input  logic [3:0]   i_wire_data_next,
    output logic         o_wire_done,
    output logic         o_wire_error,
    output logic [2:0]   o_wire_error_type,
    output logic         o_wire_M_AXI_ARID,
    output logic [31:0]  o_wire_M_AXI_ARADDR,
    output logic [7:0]   o_wire_M_AXI_ARLEN,
    output logic [2:0]   o_wire_M_AXI_ARSIZE,
    output logic [1:0]   o_wire_M_AXI_ARBURST,
    output logic         o_wire_M_AXI_ARLOCK,
    output logic [3:0]   o_wire_M_AXI_ARCACHE,
    output logic [2:0]   o_wire_M_AXI_ARPROT,
    output logic [3:0]   o_wire_M_AXI_ARQOS,
    output logic         o_wire_M_AXI_ARVALID,
    input  logic         i_wire_M_AXI_ARREADY,
    input  logic         i_wire_M_AXI_RID,
    input  logic [31:0]  i_wire_M_AXI_RDATA,
    input  logic [1:0]   i_wire_M_AXI_RRESP,
    input  logic         i_wire_M_AXI_RLAST,
    input  logic         i_wire_M_AXI_RVALID,
    output logic         o_wire_M_AXI_RREADY
);
    state_e      state_q, state_d;
    err_type_e   err_type_q;
    logic [1:0]  idx_q;
    logic [31:0] addr_q, len_q, offset_q, araddr_q;
    logic [8:0]  burst_q, beat_q;
    logic [7:0]  arlen_q;

    logic [31:0] calc_raddr, offset_next;
    logic [8:0]  calc_burst;
    logic [1:0]  route_idx;
    logic        route_ok, next_sel, beat_fire, last_beat, wdog_hit;
    logic        unused_ok;

    painterengine_gpu_dma_burst_calc u_burst_calc (
        .addr_i   (addr_q),
        .offset_i (offset_q),
        .len_i    (len_q),
        .raddr_o  (calc_raddr),
        .burst_o  (calc_burst)
    );

    always_comb begin
        route_ok  = 1'b1;
        route_idx = 2'd0;
        case (i_wire_router)
            4'b0001: route_idx = 2'd0;
            4'b0010: route_idx = 2'd1;
            4'b0100: route_idx = 2'd2;
            4'b1000: route_idx = 2'd3;
            default: route_ok  = 1'b0;
        endcase
    end

    assign next_sel    = i_wire_data_next[idx_q];
    assign beat_fire   = (state_q == ST_DATA) && i_wire_M_AXI_RVALID && next_sel;
    assign last_beat   = (beat_q == burst_q - 9'd1);
    assign offset_next = offset_q + {23'd0, burst_q};

`ifdef PAINTERENGINE_GPU_READER_TIMEOUT_EN
    logic [15:0] wdog_q;

    // Only an idle bus counts; RVALID held by consumer backpressure restarts the count.
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            wdog_q <= 16'd0;
        end else if ((state_q == ST_ADDR && !i_wire_M_AXI_ARREADY) ||
                     (state_q == ST_DATA && !i_wire_M_AXI_RVALID)) begin
            wdog_q <= wdog_q + 16'd1;
        end else begin
            wdog_q <= 16'd0;
        end
    end

    assign wdog_hit = (wdog_q == 16'(PARAM_TIMEOUT));
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q <= ST_ROUTING;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ROUTING: state_d = route_ok ? ST_CHECK : ST_ERR_ROUTING;
            ST_CHECK: begin
                if (addr_q[1:0] != 2'b00) begin
                    state_d = ST_ERR_ALIGN;
                end else if (len_q == 32'd0) begin
                    state_d = ST_ERR_LENGTH;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: state_d = ST_ADDR;
            ST_ADDR: begin
                if (wdog_hit) begin
                    state_d = ST_ERR_TIMEOUT;
                end else if (i_wire_M_AXI_ARREADY) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat_fire) begin
                    if (i_wire_M_AXI_RRESP[1]) begin
                        state_d = ST_ERR_RRESP;
                    end else if (i_wire_M_AXI_RLAST != last_beat) begin
                        state_d = ST_ERR_RLAST;
                    end else if (last_beat) begin
                        state_d = (offset_next == len_q) ? ST_DONE : ST_CALC;
                    end
                end else if (wdog_hit) begin
                    state_d = ST_ERR_TIMEOUT;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            idx_q      <= 2'd0;
            addr_q     <= 32'd0;
            len_q      <= 32'd0;
            offset_q   <= 32'd0;
            araddr_q   <= 32'd0;
            arlen_q    <= 8'hFF;
            burst_q    <= 9'd0;
            beat_q     <= 9'd0;
            err_type_q <= ET_NONE;
        end else begin
            if (state_q == ST_ROUTING) begin
                idx_q  <= route_idx;
                addr_q <= i_wire_address[{route_idx, 5'd0} +: 32];
                len_q  <= i_wire_length[{route_idx, 5'd0} +: 32];
            end
            if (state_q == ST_CALC) begin
                araddr_q <= calc_raddr;
                arlen_q  <= 8'(calc_burst - 9'd1);
                burst_q  <= calc_burst;
            end
            if (state_q == ST_ADDR && i_wire_M_AXI_ARREADY) begin
                beat_q <= 9'd0;
            end
            if (beat_fire) begin
                beat_q <= beat_q + 9'd1;
                if (last_beat) begin
                    offset_q <= offset_next;
                end
            end
            if (state_d[4] && !state_q[4]) begin
                err_type_q <= err_code(state_d);
            end
        end
    end

    always_comb begin
        o_wire_data          = '0;
        o_wire_data_valid    = '0;
        o_wire_M_AXI_RREADY  = 1'b0;
        o_wire_M_AXI_ARVALID = (state_q == ST_ADDR);
        if (state_q == ST_DATA) begin
            o_wire_data[{idx_q, 5'd0} +: 32] = i_wire_M_AXI_RDATA;
            o_wire_data_valid[idx_q]         = i_wire_M_AXI_RVALID;
            o_wire_M_AXI_RREADY              = next_sel;
        end
    end

    assign o_wire_done          = (state_q == ST_DONE);
    assign o_wire_error         = state_q[4];
    assign o_wire_error_type    = err_type_q;
    assign o_wire_M_AXI_ARID    = 1'b0;
    assign o_wire_M_AXI_ARADDR  = araddr_q;
    assign o_wire_M_AXI_ARLEN   = arlen_q;
    assign o_wire_M_AXI_ARSIZE  = AXI_ARSIZE_4B;
    assign o_wire_M_AXI_ARBURST = AXI_ARBURST_INC;
    assign o_wire_M_AXI_ARLOCK  = 1'b0;
    assign o_wire_M_AXI_ARCACHE = AXI_ARCACHE;
    assign o_wire_M_AXI_ARPROT  = 3'd0;
    assign o_wire_M_AXI_ARQOS   = 4'd0;
    assign unused_ok = ^{i_wire_M_AXI_RID, i_wire_M_AXI_RRESP[0],
                         PARAM_DATA_ALIGN[0], PARAM_TIMEOUT[0]};
endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Directed and randomized bench for painterengine_gpu_dma_reader with an AXI slave and burst/word reference model.
module tb_painterengine_gpu_dma_reader;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   router;
    logic [127:0] address, length;
    logic [127:0] data;
    logic [3:0]   valid, next;
    logic         done, error;
    logic [2:0]   etype;
    logic         arid, arlock, arvalid, arready;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize, arprot;
    logic [1:0]   arburst;
    logic [3:0]   arcache, arqos;
    logic         rid, rlast, rvalid, rready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;

    always #5 clk = ~clk;

    painterengine_gpu_dma_reader dut (
        .i_wire_clock(clk), .i_wire_resetn(rst_n), .i_wire_router(router),
        .i_wire_address(address), .i_wire_length(length), .o_wire_data(data),
        .o_wire_data_valid(valid), .i_wire_data_next(next), .o_wire_done(done),
        .o_wire_error(error), .o_wire_error_type(etype),
        .o_wire_M_AXI_ARID(arid), .o_wire_M_AXI_ARADDR(araddr), .o_wire_M_AXI_ARLEN(arlen),
        .o_wire_M_AXI_ARSIZE(arsize), .o_wire_M_AXI_ARBURST(arburst), .o_wire_M_AXI_ARLOCK(arlock),
        .o_wire_M_AXI_ARCACHE(arcache), .o_wire_M_AXI_ARPROT(arprot), .o_wire_M_AXI_ARQOS(arqos),
        .o_wire_M_AXI_ARVALID(arvalid), .i_wire_M_AXI_ARREADY(arready),
        .i_wire_M_AXI_RID(rid), .i_wire_M_AXI_RDATA(rdata), .i_wire_M_AXI_RRESP(rresp),
        .i_wire_M_AXI_RLAST(rlast), .i_wire_M_AXI_RVALID(rvalid), .o_wire_M_AXI_RREADY(rready)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] seed;
    logic [31:0] eba[$];
    int          ebl[$];
    logic [31:0] ew[$];
    logic [31:0] sq_addr[$];
    int          sq_len[$];
    int beat_in, gbeat, cycles, ar_count, arv_seen, cur_ch, cur_budget;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ seed;
    endfunction

    task automatic drive_inputs(input int nmode, input int vmode, input int err_rresp, input int err_rlast);
        case (vmode)
            0:       arready = 1'b1;
            1:       arready = 1'($urandom_range(0, 1));
            default: arready = 1'b0;
        endcase
        case (nmode)
            0: next = 4'hF;
            1: begin
                next = 4'($urandom);
                next[cur_ch] = (cycles % 4 == 0) || (cycles % 4 == 3);
            end
            default: next = 4'($urandom);
        endcase
        if (sq_addr.size() == 0) begin
            rvalid = 1'b0; rdata = 32'd0; rlast = 1'b0; rresp = 2'b00;
        end else begin
            if (!rvalid) rvalid = (vmode == 0) || ($urandom_range(0, 2) != 0);
            rdata = mem_word(sq_addr[0] + 32'(4 * beat_in));
            rlast = (beat_in == sq_len[0] - 1) || (gbeat == err_rlast);
            rresp = (gbeat == err_rresp) ? 2'b10 : 2'b00;
        end
    endtask

    task automatic run_txn(input logic [3:0] rt, input logic [31:0] a, input logic [31:0] n,
                           input int nmode, input int vmode, input int err_rresp,
                           input int err_rlast, input int budget);
        longint unsigned a_cur, rem, room, b;
        logic in_burst, ar_hs, r_hs;
        logic [127:0] exp_data;
        cur_ch = rt[1] ? 1 : rt[2] ? 2 : rt[3] ? 3 : 0;
        cur_budget = budget;
        eba.delete(); ebl.delete(); ew.delete(); sq_addr.delete(); sq_len.delete();
        a_cur = a; rem = n;
        while (rem > 0) begin
            room = (1024 - (a_cur % 1024)) / 4;
            b = (room < rem) ? room : rem;
            eba.push_back(32'(a_cur)); ebl.push_back(int'(b));
            a_cur += 4 * b; rem -= b;
        end
        for (int k = 0; k < int'(n); k++) ew.push_back(mem_word(a + 32'(4 * k)));
        router = rt;
        address = {$urandom, $urandom, $urandom, $urandom};
        length  = {$urandom, $urandom, $urandom, $urandom};
        address[32*cur_ch +: 32] = a;
        length[32*cur_ch +: 32]  = n;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rlast = 1'b0; rresp = 2'b00; next = 4'hF;
        beat_in = 0; gbeat = 0; cycles = 0; ar_count = 0; arv_seen = 0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_arvalid", 128'(arvalid), 128'(0));
        check("rst_araddr", 128'(araddr), 128'(0));
        check("rst_arlen", 128'(arlen), 128'(8'hFF));
        check("rst_valid_rready", 128'({valid, rready}), 128'(0));
        check("rst_done_err_type", 128'({done, error, etype}), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        forever begin
            drive_inputs(nmode, vmode, err_rresp, err_rlast);
            @(negedge clk);
            if (done || error || cycles >= budget) break;
            in_burst = (sq_addr.size() != 0);
            ar_hs = 1'b0;
            if (arvalid) begin
                arv_seen++;
                check("ar_in_data", 128'(in_burst), 128'(0));
                check("ar_fixed", 128'({arid, arsize, arburst, arlock, arcache, arprot, arqos}),
                      128'({1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000}));
                if (eba.size() == 0) begin
                    check("ar_extra", 128'(arvalid), 128'(0));
                end else begin
                    check("araddr", 128'(araddr), 128'(eba[0]));
                    check("arlen", 128'(arlen), 128'(ebl[0] - 1));
                    ar_hs = arready;
                end
            end
            check("rready", 128'(rready), 128'(in_burst ? next[cur_ch] : 1'b0));
            check("data_valid", 128'(valid), 128'((in_burst && rvalid) ? (4'b0001 << cur_ch) : 4'b0000));
            exp_data = in_burst ? (128'(rdata) << (32 * cur_ch)) : 128'd0;
            check("data_route", data, exp_data);
            r_hs = in_burst && rvalid && next[cur_ch];
            if (r_hs) begin
                if (ew.size() == 0) check("word_extra", 128'(r_hs), 128'(0));
                else check("word", 128'(data[32*cur_ch +: 32]), 128'(ew.pop_front()));
            end
            @(posedge clk);
            #1;
            if (ar_hs) begin
                ar_count++;
                sq_addr.push_back(eba.pop_front());
                sq_len.push_back(ebl.pop_front());
            end
            if (r_hs) begin
                beat_in++; gbeat++; rvalid = 1'b0;
                if (beat_in == sq_len[0]) begin
                    void'(sq_addr.pop_front()); void'(sq_len.pop_front()); beat_in = 0;
                end
            end
            cycles++;
        end
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_budget"}, 128'(cycles < cur_budget), 128'(1));
        check({tag, "_done_err"}, 128'({done, error, etype}), 128'({1'b1, 1'b0, 3'd0}));
        check({tag, "_words_left"}, 128'(ew.size()), 128'(0));
        check({tag, "_bursts_left"}, 128'(eba.size()), 128'(0));
    endtask

    task automatic expect_err(input string tag, input logic [2:0] t);
        check({tag, "_budget"}, 128'(cycles < cur_budget), 128'(1));
        check({tag, "_err"}, 128'({done, error, etype}), 128'({1'b0, 1'b1, t}));
    endtask

    initial begin
        rid = 1'b0;
        seed = $urandom;

        run_txn(4'b0010, 32'h1000, 32'd8, 0, 0, -1, -1, 200);
        expect_done("single_burst");
        check("single_ar_count", 128'(ar_count), 128'(1));

        run_txn(4'b0001, 32'h13F0, 32'd10, 0, 0, -1, -1, 200);
        expect_done("kb_split");
        check("kb_split_ar_count", 128'(ar_count), 128'(2));

        run_txn(4'b0011, 32'h1000, 32'd4, 0, 0, -1, -1, 50);
        expect_err("bad_route", 3'd1);
        check("bad_route_no_ar", 128'(arv_seen), 128'(0));
        run_txn(4'b0100, 32'h1002, 32'd4, 0, 0, -1, -1, 50);
        expect_err("misalign", 3'd2);
        check("misalign_no_ar", 128'(arv_seen), 128'(0));
        run_txn(4'b1000, 32'h2000, 32'd0, 0, 0, -1, -1, 50);
        expect_err("zero_len", 3'd3);
        check("zero_len_no_ar", 128'(arv_seen), 128'(0));

        run_txn(4'b0100, 32'h3000, 32'd4, 1, 0, -1, -1, 200);
        expect_done("next_toggle");

        run_txn(4'b0001, 32'h4000, 32'd8, 2, 1, 2, -1, 500);
        expect_err("rresp", 3'd5);
        check("rresp_words_left", 128'(ew.size()), 128'(5));
        run_txn(4'b1000, 32'h5000, 32'd4, 0, 0, -1, 1, 200);
        expect_err("rlast", 3'd6);

`ifdef PAINTERENGINE_GPU_READER_TIMEOUT_EN
        run_txn(4'b0010, 32'h6000, 32'd4, 0, 3, -1, -1, 400);
        expect_err("timeout", 3'd4);
        check("timeout_cycles", 128'(cycles >= 250 && cycles <= 270), 128'(1));
`else
        run_txn(4'b0010, 32'h6000, 32'd4, 0, 3, -1, -1, 1000);
        check("no_timeout_arvalid", 128'({arvalid, error}), 128'({1'b1, 1'b0}));
`endif

        for (int t = 0; t < 6; t++) begin
            logic [3:0]  rt;
            logic [31:0] a, n;
            rt = 4'b0001 << $urandom_range(0, 3);
            a  = $urandom & 32'h000F_FFFC;
            n  = 32'($urandom_range(1, 600));
            run_txn(rt, a, n, 2, 1, -1, -1, 8000);
            expect_done("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
